// File: rtl/data_mem_bytelane.sv
// Byte-addressed RV32I data memory: four byte-lane arrays with per-lane write
// enables, registered sign/zero-extended loads and registered fault flags.
module data_mem_bytelane #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writedata,
    output logic [31:0] ReadData,
    output logic        misaligned,
    output logic        out_of_range
);
    localparam int IDXW = $clog2(DEPTH_WORDS);

    logic [31:0]     offset;
    logic [IDXW-1:0] word_idx;
    logic [1:0]      lane;
    logic            in_range;

    // Offsets below BASE_ADDR wrap to huge values and fail the high-bit test.
    assign offset   = ALUResult - BASE_ADDR;
    assign word_idx = offset[IDXW+1:2];
    assign lane     = offset[1:0];
    assign in_range = ~|offset[31:IDXW+2];

    logic        legal_load;
    logic        legal_store;
    logic        align_fail;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [3:0]  we;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    always_comb begin
        legal_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        legal_load  = legal_store || (funct3 == 3'b100) || (funct3 == 3'b101);

        align_fail = 1'b0;
        lane_mask  = 4'b0000;
        lane_wdata = writedata;
        case (funct3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << lane;
                lane_wdata = {4{writedata[7:0]}};
            end
            2'b01: begin
                align_fail = lane[0];
                lane_mask  = lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{writedata[15:0]}};
            end
            2'b10: begin
                align_fail = |lane;
                lane_mask  = 4'b1111;
            end
            default: begin
                align_fail = 1'b0;
                lane_mask  = 4'b0000;
            end
        endcase

        we = {4{MemWrite & ~reset & legal_store & ~align_fail & in_range}} & lane_mask;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS] = '{default: 8'h00};

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem_lane[word_idx] <= lane_wdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = mem_lane[word_idx];
        end
    endgenerate

    // Little-endian lane selection, then extension by funct3.
    always_comb begin
        byte_sel   = rd_word[7:0];
        half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_value = 32'h0;
        case (lane)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        case (funct3)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_value = rd_word;
            3'b100:  load_value = {24'h0, byte_sel};
            3'b101:  load_value = {16'h0, half_sel};
            default: load_value = 32'h0;
        endcase
    end

    logic access;
    logic legal_op;
    assign access   = MemRead | MemWrite;
    assign legal_op = (MemRead & legal_load) | (MemWrite & legal_store);

    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData     <= 32'h0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            misaligned   <= access & align_fail & legal_op;
            out_of_range <= access & ~in_range;
            if (MemRead) begin
                ReadData <= (legal_load & ~align_fail & in_range) ? load_value : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_bytelane.sv
// Table-driven bench for data_mem_bytelane with a queue scoreboard of
// expected ReadData / fault flags, one line printed per transaction.
module tb_data_mem_bytelane;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] writedata;
    logic [31:0] ReadData;
    logic        misaligned;
    logic        out_of_range;

    data_mem_bytelane #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .funct3      (funct3),
        .ALUResult   (ALUResult),
        .writedata   (writedata),
        .ReadData    (ReadData),
        .misaligned  (misaligned),
        .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic        oor;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic        oor;
    } exp_t;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] last_rd;

    function automatic vec_t mk(input logic rst, input logic we, input logic re,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic mis, input logic oor);
        vec_t v;
        v.rst = rst; v.we = we; v.re = re; v.f3 = f3; v.addr = addr;
        v.wd = wd; v.rd = rd; v.mis = mis; v.oor = oor;
        return v;
    endfunction

    task automatic apply(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset     = v.rst;
        MemWrite  = v.we;
        MemRead   = v.re;
        funct3    = v.f3;
        ALUResult = v.addr;
        writedata = v.wd;
        sb.push_back({v.rd, v.mis, v.oor});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = {ReadData, misaligned, out_of_range};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: rst=%0b we=%0b re=%0b f3=%03b addr=%08h got rd=%08h mis=%0b oor=%0b need rd=%08h mis=%0b oor=%0b",
                     name, v.rst, v.we, v.re, v.f3, v.addr, ReadData, misaligned, out_of_range,
                     e.rd, e.mis, e.oor);
        end else begin
            $display("ok   %s: addr=%08h rd=%08h mis=%0b oor=%0b", name, v.addr, ReadData,
                     misaligned, out_of_range);
        end
        last_rd = e.rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; funct3 = W;
        ALUResult = 32'h0; writedata = 32'h0;

        //          rst   we    re    f3  addr           wd             rd             mis   oor
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, W,  32'h0000_0000, 32'h0,         32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, W,  32'h0000_0010, 32'hDEADBEEF, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0010, 32'h0,         32'hDEADBEEF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, B,  32'h0000_0011, 32'hAABBCC55, 32'hDEADBEEF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0010, 32'h0,         32'hDEAD55EF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, B,  32'h0000_0013, 32'h0,         32'hFFFFFFDE, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, BU, 32'h0000_0013, 32'h0,         32'h000000DE, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, H,  32'h0000_0012, 32'h0,         32'hFFFFDEAD, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, HU, 32'h0000_0012, 32'h0,         32'h0000DEAD, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, B,  32'h0000_0011, 32'h0,         32'h00000055, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, H,  32'h0000_0010, 32'h0,         32'h000055EF, 1'b0, 1'b0));
        // misalignment
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, W,  32'h0000_0020, 32'h12345678, 32'h000055EF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, H,  32'h0000_0021, 32'h0000FFFF, 32'h000055EF, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0022, 32'h0,         32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0020, 32'h0,         32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, H,  32'h0000_0022, 32'h9999ABCD, 32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0020, 32'h0,         32'hABCD5678, 1'b0, 1'b0));
        // range boundaries
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, W,  32'h0000_0400, 32'hCAFEF00D, 32'hABCD5678, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0400, 32'h0,         32'h0,         1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0000, 32'h0,         32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, W,  32'h0000_03FC, 32'h0BADF00D, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_03FC, 32'h0,         32'h0BADF00D, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0402, 32'h0,         32'h0,         1'b1, 1'b1));
        // illegal funct3 codes
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0010, 32'h0,         32'hDEAD55EF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b011, 32'h0000_0010, 32'h0,     32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, BU, 32'h0000_0010, 32'hFFFFFFFF, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, W,  32'h0000_0402, 32'h0,         32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0010, 32'h0,         32'hDEAD55EF, 1'b0, 1'b0));
        // read-before-write on the same word
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, W,  32'h0000_0030, 32'h11111111, 32'hDEAD55EF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, W,  32'h0000_0030, 32'h22222222, 32'h11111111, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0030, 32'h0,         32'h22222222, 1'b0, 1'b0));
        // reset during a store: store dropped, array kept
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, W,  32'h0000_0040, 32'h5A5A5A5A, 32'h22222222, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0040, 32'h0,         32'h5A5A5A5A, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, W,  32'h0000_0040, 32'hFFFFFFFF, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, W,  32'h0000_0040, 32'h0,         32'h5A5A5A5A, 1'b0, 1'b0));

        repeat (2) @(posedge clk);
        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // Random write-then-read of whole words, checked against a bench-side value.
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'($urandom_range(0, 255)) << 2;
            d = $urandom;
            apply($sformatf("rnd_sw%0d", i), mk(1'b0, 1'b1, 1'b0, W, a, d, last_rd, 1'b0, 1'b0));
            apply($sformatf("rnd_lw%0d", i), mk(1'b0, 1'b0, 1'b1, W, a, 32'h0, d, 1'b0, 1'b0));
        end

        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_bytelane.md
Name: data_mem_bytelane

Overview:
- Parametrised successor to the single-cycle word data memory.
- Adds RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) through byte-lane write enables and sign/zero extension.
- Read data is registered, with one-cycle latency. Misaligned and out-of-range accesses are flagged.
- Sits between the ALU (address) / register file (store data) and the writeback mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  store request, sampled at the rising edge.
- MemRead  input  1  load request, sampled at the rising edge.
- funct3  input  3  RV32I load/store width and sign code.
- ALUResult  input  32  byte address.
- writedata  input  32  store data; the low byte or halfword is used for SB/SH.
- ReadData  output  32  registered, extended load result.
- misaligned  output  1  registered fault: previous access was misaligned.
- out_of_range  output  1  registered fault: previous access was outside the array.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Address decode:
  - offset = ALUResult - BASE_ADDR (32-bit wrap).
  - idx = offset[31:2]; lane = offset[1:0].
  - Out of range when idx >= DEPTH_WORDS, including offsets that wrap below BASE_ADDR.
- Alignment rules:
  - Byte access (funct3[1:0]=00) is always aligned.
  - Half access (01) requires lane[0]=0.
  - Word access (10) requires lane=00.
- Legal funct3 codes:
  - Stores: 000 SB, 001 SH, 010 SW.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Any other code is illegal for that operation.
- Store (MemWrite=1, reset=0, legal, aligned, in range):
  - SB writes writedata[7:0] to byte lane `lane`; other bytes unchanged.
  - SH writes writedata[15:0] to bytes lane and lane+1.
  - SW writes all 4 bytes.
- Store suppression: a faulting or illegal store writes nothing.
- Load (MemRead=1, reset=0):
  - At the edge, ReadData <= extended value from the pre-edge array contents.
  - LB/LH sign-extend; LBU/LHU zero-extend. Byte/half is selected by lane, little-endian.
  - A faulting or illegal load sets ReadData <= 0.
- ReadData holds its value when MemRead=0.
- Latency: data for a load presented in cycle N is visible after edge N, i.e. during cycle N+1.
- Simultaneous MemRead and MemWrite to the same word: read-before-write. ReadData gets the old contents; the store takes effect for the next access.
- Fault flags:
  - At each edge, misaligned <= (MemRead|MemWrite) & aligned-check fail & legal funct3.
  - At each edge, out_of_range <= (MemRead|MemWrite) & range fail.
  - Both flags may be 1 together.
  - Both flags are 0 after any edge with no access.
- Reset (edge with reset=1):
  - ReadData=0, misaligned=0, out_of_range=0.
  - Any MemWrite in that cycle is ignored.
  - Array contents are not cleared by reset.
- Array initial contents: all words zero at time 0.
- Back-to-back accesses every cycle are supported; there are no stalls and no handshake.

Test Plan:
1. SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> ReadData=0xDEADBEEF one cycle after the load; flags 0.
2. After test 1, SB 0x55 to 0x11, then:
   - LW 0x10 -> 0xDEAD55EF.
   - LB 0x13 -> 0xFFFFFFDE.
   - LBU 0x13 -> 0x000000DE.
   - LH 0x12 -> 0xFFFFDEAD.
   - LHU 0x12 -> 0x0000DEAD.
3. SH to 0x21, and LW from 0x22 -> misaligned=1 for one cycle; word 0x20 unchanged; ReadData=0 after the LW.
4. With DEPTH_WORDS=256, SW to 0x400, then LW 0x400 -> out_of_range=1; ReadData=0; no word modified. Also LW 0x3FC returns that word's stored value.
5. Word 0x30=0x11111111; same cycle MemRead=1 (LW 0x30) and MemWrite=1 (SW 0x22222222, 0x30) -> ReadData=0x11111111; next LW 0x30 -> 0x22222222.
6. Assert reset during a SW to 0x40 with ReadData nonzero -> after the edge, ReadData=0 and flags 0; LW 0x40 returns the prior value. A 5-iteration random address/data write-then-read loop must match a scoreboard.
